// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM states, the bubble word and the default memory geometry.
package instr_fetch_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_WORD           = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam int unsigned DEFAULT_IMEM_WORDS = 64;

  // Forces a byte address onto a word boundary so the PC never holds stray low bits.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic pc_in_range(input logic [31:0] pc, input logic [32:0] limit_bytes);
    return ({1'b0, pc} < limit_bytes);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched instruction unless stalled.
// A flush always wins over a stall and turns the slot into a bubble.
module if_id_reg
  import instr_fetch_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc_plus4,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc_plus4,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;

  // A bubble keeps the old pc_plus4 but replaces the instruction with a NOP.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_instr    <= NOP_WORD;
      r_pc_plus4 <= 32'h0;
      r_valid    <= 1'b0;
    end else if (i_flush) begin
      r_instr    <= NOP_WORD;
      r_valid    <= 1'b0;
    end else if (!i_stall) begin
      r_instr    <= i_instr;
      r_pc_plus4 <= i_pc_plus4;
      r_valid    <= 1'b1;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, RUN/HALT fault FSM and fetch counter.
// The instruction memory is combinational, so IF/ID sees each word one edge after its address.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_WORDS = DEFAULT_IMEM_WORDS
)(
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_target,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_instr,
  output logic [31:0] o_if_id_instr,
  output logic [31:0] o_if_id_pc_plus4,
  output logic        o_if_id_valid,
  output logic        o_fetch_fault,
  output logic [31:0] o_fetch_count
);

  localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) << 2;

  fetch_state_e r_state;
  fetch_state_e w_state_next;

  logic [31:0] r_pc;
  logic [31:0] r_fetch_count;
  logic [31:0] w_pc_next;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic        w_pc_in_range;
  logic        w_target_in_range;
  logic        w_ifid_stall;
  logic        w_ifid_flush;
  logic        w_count_en;
  logic        w_fault;

  assign w_pc_plus4        = r_pc + 32'd4;
  assign w_target          = align_word(i_redirect_target);
  assign w_pc_in_range     = pc_in_range(r_pc, IMEM_BYTES);
  assign w_target_in_range = pc_in_range(w_target, IMEM_BYTES);

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= ST_RUN;
    else         r_state <= w_state_next;
  end

  // A redirect always beats the range check, so a jump away from a bad PC never faults.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:  if (!i_redirect_valid && !w_pc_in_range) w_state_next = ST_HALT;
      ST_HALT: if (i_redirect_valid && w_target_in_range) w_state_next = ST_RUN;
      default: w_state_next = ST_RUN;
    endcase
  end

  always_comb begin
    w_pc_next    = r_pc;
    w_ifid_stall = 1'b0;
    w_ifid_flush = 1'b0;
    w_count_en   = 1'b0;
    w_fault      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (i_redirect_valid) begin
          w_pc_next    = w_target;
          w_ifid_flush = 1'b1;
        end else if (!w_pc_in_range) begin
          w_ifid_flush = 1'b1;
        end else begin
          w_ifid_stall = i_stall;
          w_ifid_flush = i_flush;
          w_count_en   = !i_stall && !i_flush;
          if (!i_stall) w_pc_next = w_pc_plus4;
        end
      end
      ST_HALT: begin
        w_fault      = 1'b1;
        w_ifid_flush = 1'b1;
        if (i_redirect_valid && w_target_in_range) w_pc_next = w_target;
      end
      default: begin
        w_ifid_flush = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_pc          <= align_word(RESET_PC);
      r_fetch_count <= 32'h0;
    end else begin
      r_pc <= w_pc_next;
      if (w_count_en) r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  if_id_reg u_if_id_reg (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_stall    (w_ifid_stall),
    .i_flush    (w_ifid_flush),
    .i_instr    (i_imem_instr),
    .i_pc_plus4 (w_pc_plus4),
    .o_instr    (o_if_id_instr),
    .o_pc_plus4 (o_if_id_pc_plus4),
    .o_valid    (o_if_id_valid)
  );

  assign o_imem_addr   = r_pc;
  assign o_fetch_fault = w_fault;
  assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with fixed expected values, then a
// randomized run compared against a cycle-level behavioural model of the fetch rules.
module tb_instr_fetch;

  localparam int          WORDS  = 64;
  localparam logic [31:0] LIMIT  = 32'(4 * WORDS);

  logic        clock = 1'b0;
  logic        reset, stall, flush, redirectValid;
  logic [31:0] redirectTarget;
  logic [31:0] imemAddr, imemInstr, ifIdInstr, ifIdPcPlus4, fetchCount;
  logic        ifIdValid, fetchFault;
  logic [31:0] mem [WORDS];

  logic [31:0] mPc, mInstr, mPc4, mCount;
  logic        mValid, mFault;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  assign imemInstr = (imemAddr < LIMIT) ? mem[imemAddr[7:2]] : 32'hDEAD_BEEF;

  instr_fetch #(.RESET_PC(32'h0), .IMEM_WORDS(WORDS)) dut (
    .i_clock           (clock),
    .i_reset           (reset),
    .i_stall           (stall),
    .i_flush           (flush),
    .i_redirect_valid  (redirectValid),
    .i_redirect_target (redirectTarget),
    .o_imem_addr       (imemAddr),
    .i_imem_instr      (imemInstr),
    .o_if_id_instr     (ifIdInstr),
    .o_if_id_pc_plus4  (ifIdPcPlus4),
    .o_if_id_valid     (ifIdValid),
    .o_fetch_fault     (fetchFault),
    .o_fetch_count     (fetchCount)
  );

  // Reference model: applies the fetch rules to the bench's own view of the pipeline.
  task automatic modelStep();
    logic [31:0] tgt;
    tgt = redirectTarget & 32'hFFFF_FFFC;
    if (reset) begin
      mPc = 32'h0; mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0; mFault = 1'b0; mCount = 32'h0;
    end else if (!mFault) begin
      if (redirectValid) begin
        mPc = tgt; mValid = 1'b0;
      end else if (mPc >= LIMIT) begin
        mFault = 1'b1; mValid = 1'b0;
      end else if (flush) begin
        mValid = 1'b0;
        if (!stall) mPc = mPc + 4;
      end else if (!stall) begin
        mInstr = mem[mPc / 4]; mPc4 = mPc + 4; mValid = 1'b1; mPc = mPc + 4; mCount = mCount + 1;
      end
    end else begin
      mValid = 1'b0;
      if (redirectValid && tgt < LIMIT) begin
        mPc = tgt; mFault = 1'b0;
      end
    end
  endtask

  task automatic tick();
    modelStep();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b1; flush = 1'b1; redirectValid = 1'b1; redirectTarget = 32'h40;
    tick();
    tick();
    checks++; if (imemAddr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr actual=%h expected=%h", imemAddr, 32'h0); end
    checks++; if (ifIdValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid actual=%b expected=0", ifIdValid); end
    checks++; if (ifIdInstr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr actual=%h expected=0", ifIdInstr); end
    checks++; if (ifIdPcPlus4 !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc4 actual=%h expected=0", ifIdPcPlus4); end
    checks++; if (fetchFault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault actual=%b expected=0", fetchFault); end
    checks++; if (fetchCount !== 32'h0) begin errors++; $display("[TB] FAIL reset_count actual=%0d expected=0", fetchCount); end
    reset = 1'b0; stall = 1'b0; flush = 1'b0; redirectValid = 1'b0;
  endtask

  task automatic test_sequential();
    checks++; if (imemAddr !== 32'h0) begin errors++; $display("[TB] FAIL seq_addr0 actual=%h expected=0", imemAddr); end
    tick();
    checks++; if (imemAddr !== 32'h4) begin errors++; $display("[TB] FAIL seq_addr1 actual=%h expected=4", imemAddr); end
    checks++; if (ifIdValid !== 1'b1 || ifIdInstr !== 32'h2008_0020 || ifIdPcPlus4 !== 32'h4) begin
      errors++; $display("[TB] FAIL seq_fetch0 actual=%b/%h/%h expected=1/20080020/4", ifIdValid, ifIdInstr, ifIdPcPlus4); end
    tick();
    checks++; if (imemAddr !== 32'h8) begin errors++; $display("[TB] FAIL seq_addr2 actual=%h expected=8", imemAddr); end
    checks++; if (ifIdValid !== 1'b1 || ifIdInstr !== 32'h2009_0027 || ifIdPcPlus4 !== 32'h8) begin
      errors++; $display("[TB] FAIL seq_fetch1 actual=%b/%h/%h expected=1/20090027/8", ifIdValid, ifIdInstr, ifIdPcPlus4); end
    checks++; if (fetchCount !== 32'd2) begin errors++; $display("[TB] FAIL seq_count actual=%0d expected=2", fetchCount); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (imemAddr !== 32'h8) begin errors++; $display("[TB] FAIL stall_addr actual=%h expected=8", imemAddr); end
      checks++; if (ifIdValid !== 1'b1 || ifIdInstr !== 32'h2009_0027 || ifIdPcPlus4 !== 32'h8) begin
        errors++; $display("[TB] FAIL stall_ifid actual=%b/%h/%h expected=1/20090027/8", ifIdValid, ifIdInstr, ifIdPcPlus4); end
      checks++; if (fetchCount !== 32'd2) begin errors++; $display("[TB] FAIL stall_count actual=%0d expected=2", fetchCount); end
    end
    stall = 1'b0;
    tick();
    checks++; if (ifIdValid !== 1'b1 || ifIdInstr !== mem[2] || ifIdPcPlus4 !== 32'hC || imemAddr !== 32'hC) begin
      errors++; $display("[TB] FAIL stall_resume actual=%b/%h/%h/%h expected=1/%h/c/c", ifIdValid, ifIdInstr, ifIdPcPlus4, imemAddr, mem[2]); end
  endtask

  task automatic test_redirect();
    stall = 1'b1; redirectValid = 1'b1; redirectTarget = 32'h3A;
    tick();
    checks++; if (imemAddr !== 32'h38) begin errors++; $display("[TB] FAIL redir_addr actual=%h expected=38", imemAddr); end
    checks++; if (ifIdValid !== 1'b0) begin errors++; $display("[TB] FAIL redir_valid actual=%b expected=0", ifIdValid); end
    checks++; if (fetchCount !== 32'd3) begin errors++; $display("[TB] FAIL redir_count actual=%0d expected=3", fetchCount); end
    stall = 1'b0; redirectValid = 1'b0;
    tick();
    checks++; if (ifIdValid !== 1'b1 || ifIdInstr !== mem[14] || ifIdPcPlus4 !== 32'h3C) begin
      errors++; $display("[TB] FAIL redir_fetch actual=%b/%h/%h expected=1/%h/3c", ifIdValid, ifIdInstr, ifIdPcPlus4, mem[14]); end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    tick();
    checks++; if (ifIdValid !== 1'b0 || imemAddr !== 32'h40 || fetchCount !== 32'd4) begin
      errors++; $display("[TB] FAIL flush_bubble actual=%b/%h/%0d expected=0/40/4", ifIdValid, imemAddr, fetchCount); end
    flush = 1'b0;
    tick();
    checks++; if (ifIdValid !== 1'b1 || ifIdInstr !== mem[16] || ifIdPcPlus4 !== 32'h44) begin
      errors++; $display("[TB] FAIL flush_recover actual=%b/%h/%h expected=1/%h/44", ifIdValid, ifIdInstr, ifIdPcPlus4, mem[16]); end
    flush = 1'b1; stall = 1'b1;
    tick();
    checks++; if (ifIdValid !== 1'b0 || imemAddr !== 32'h44) begin
      errors++; $display("[TB] FAIL flush_stall actual=%b/%h expected=0/44", ifIdValid, imemAddr); end
    flush = 1'b0; stall = 1'b0;
  endtask

  task automatic test_fault();
    redirectValid = 1'b1; redirectTarget = 32'hF8;
    tick();
    redirectValid = 1'b0;
    tick();
    tick();
    checks++; if (imemAddr !== 32'h100 || ifIdValid !== 1'b1 || ifIdInstr !== mem[63] || fetchFault !== 1'b0) begin
      errors++; $display("[TB] FAIL fault_last actual=%h/%b/%h/%b expected=100/1/%h/0", imemAddr, ifIdValid, ifIdInstr, fetchFault, mem[63]); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (fetchFault !== 1'b1 || ifIdValid !== 1'b0 || imemAddr !== 32'h100) begin
        errors++; $display("[TB] FAIL fault_halt actual=%b/%b/%h expected=1/0/100", fetchFault, ifIdValid, imemAddr); end
    end
    redirectValid = 1'b1; redirectTarget = 32'h200;
    tick();
    checks++; if (fetchFault !== 1'b1 || imemAddr !== 32'h100) begin
      errors++; $display("[TB] FAIL fault_bad_redir actual=%b/%h expected=1/100", fetchFault, imemAddr); end
    redirectTarget = 32'h10;
    tick();
    checks++; if (fetchFault !== 1'b0 || imemAddr !== 32'h10 || ifIdValid !== 1'b0) begin
      errors++; $display("[TB] FAIL fault_exit actual=%b/%h/%b expected=0/10/0", fetchFault, imemAddr, ifIdValid); end
    redirectValid = 1'b0;
    tick();
    checks++; if (ifIdValid !== 1'b1 || ifIdInstr !== mem[4] || ifIdPcPlus4 !== 32'h14) begin
      errors++; $display("[TB] FAIL fault_refetch actual=%b/%h/%h expected=1/%h/14", ifIdValid, ifIdInstr, ifIdPcPlus4, mem[4]); end
  endtask

  task automatic test_back_to_back();
    redirectValid = 1'b1; redirectTarget = 32'h20;
    tick();
    redirectTarget = 32'h83;
    tick();
    checks++; if (imemAddr !== 32'h80 || ifIdValid !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_addr actual=%h/%b expected=80/0", imemAddr, ifIdValid); end
    redirectValid = 1'b0;
    tick();
    checks++; if (ifIdValid !== 1'b1 || ifIdInstr !== mem[32] || ifIdPcPlus4 !== 32'h84) begin
      errors++; $display("[TB] FAIL b2b_fetch actual=%b/%h/%h expected=1/%h/84", ifIdValid, ifIdInstr, ifIdPcPlus4, mem[32]); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset          = ($urandom_range(0, 79) == 0);
      stall          = ($urandom_range(0, 3) == 0);
      flush          = ($urandom_range(0, 7) == 0);
      redirectValid  = ($urandom_range(0, 11) == 0);
      redirectTarget = $urandom_range(0, 32'h11F);
      tick();
      checks++; if (imemAddr !== mPc || fetchFault !== mFault || ifIdValid !== mValid || fetchCount !== mCount) begin
        errors++; $display("[TB] FAIL rand_state cyc=%0d actual=%h/%b/%b/%0d expected=%h/%b/%b/%0d", i, imemAddr, fetchFault, ifIdValid, fetchCount, mPc, mFault, mValid, mCount); end
      if (mValid) begin
        checks++; if (ifIdInstr !== mInstr || ifIdPcPlus4 !== mPc4) begin
          errors++; $display("[TB] FAIL rand_ifid cyc=%0d actual=%h/%h expected=%h/%h", i, ifIdInstr, ifIdPcPlus4, mInstr, mPc4); end
      end
    end
    reset = 1'b0; stall = 1'b0; flush = 1'b0; redirectValid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0020;
    mem[1] = 32'h2009_0027;
    mPc = 32'h0; mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0; mFault = 1'b0; mCount = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_flush();
    test_fault();
    test_back_to_back();
    test_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address loaded into the PC on reset.
REQ-002 Parameter IMEM_WORDS, default 64, number of 32-bit words in instruction memory; in-range PC is < 4*IMEM_WORDS.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  decode not ready; hold PC and IF/ID register.
REQ-006 flush  input  1  squash the IF/ID contents (insert bubble).
REQ-007 redirect_valid  input  1  taken branch/jump this cycle.
REQ-008 redirect_target  input  32  byte address of branch/jump target.
REQ-009 imem_addr  output  32  byte address to instruction memory (equals PC).
REQ-010 imem_instr  input  32  combinational instruction word returned for imem_addr.
REQ-011 if_id_instr  output  32  registered instruction for decode.
REQ-012 if_id_pc_plus4  output  32  registered PC+4 of that instruction.
REQ-013 if_id_valid  output  1  IF/ID holds a real instruction.
REQ-014 fetch_fault  output  1  PC out of range; fetch halted.
REQ-015 fetch_count  output  32  number of instructions accepted into IF/ID since reset.

Function
REQ-016 imem_addr SHALL be driven combinationally from the PC register, with no added latency.
REQ-017 The instruction at imem_addr SHALL appear on if_id_instr/if_id_valid one cycle later (1-cycle fetch latency).
REQ-018 States: RUN, HALT; reset enters RUN.
REQ-019 RUN, no stall/redirect: PC <= PC+4; IF/ID <= {imem_instr, PC+4, valid=1}; fetch_count += 1.
REQ-020 RUN, stall=1 and no redirect: PC, IF/ID, and fetch_count hold their values.
REQ-021 redirect_valid=1 overrides stall: PC <= {redirect_target[31:2], 2'b00}; IF/ID valid <= 0; fetch_count unchanged.
REQ-022 flush=1 without redirect: IF/ID valid <= 0; PC advances per REQ-019 (or holds per REQ-020 if stalled). Flush overrides stall for IF/ID only.
REQ-023 If the PC about to be latched into IF/ID is >= 4*IMEM_WORDS, the block SHALL go to HALT, set fetch_fault=1, and load IF/ID valid=0.
REQ-024 In HALT, the PC holds, if_id_valid=0, and fetch_fault=1.
REQ-025 HALT exits to RUN only on reset, or on a redirect to an in-range target; fetch_fault clears in the same edge.
REQ-026 PC+4 arithmetic is modulo 2^32; fetch_count wraps modulo 2^32.
REQ-027 The low two bits of the PC SHALL always be zero.

Reset
REQ-028 On reset: PC=RESET_PC, if_id_instr=0, if_id_pc_plus4=0, if_id_valid=0, fetch_fault=0, fetch_count=0, state=RUN.
REQ-029 Reset overrides stall, flush, and redirect in the same cycle.
REQ-030 Reset asserted mid-operation discards IF/ID contents; the first fetch after deassertion is at RESET_PC.

Structure
REQ-031 A shared package holds the state enum (RUN, HALT), the NOP word 32'h0, and the default RESET_PC/IMEM_WORDS constants.
REQ-032 One sub-module, if_id_reg, holds the IF/ID pipeline register with stall and flush enables; PC logic and the FSM stay in instr_fetch.

Verification
REQ-033 Reset, then release with memory word0=32'h20080020, word1=32'h20090027 -> imem_addr sequence 0, 4, 8; if_id_instr=32'h20080020 with pc_plus4=4 one cycle after release, then 32'h20090027 with pc_plus4=8.
REQ-034 stall held 3 cycles at PC=8 -> imem_addr stays 8; IF/ID stays unchanged; fetch_count unchanged; fetching resumes at 8 on release.
REQ-035 redirect_valid=1 with target=32'h3A and stall=1 -> next PC=32'h38, if_id_valid=0, then the instruction at 32'h38 is fetched.
REQ-036 Sequential run past PC=0xFC (IMEM_WORDS=64) -> at PC=0x100, fetch_fault=1, if_id_valid=0, PC held at 0x100; redirect to 0x10 -> fault clears, fetch at 0x10.
REQ-037 flush=1 for one cycle in RUN -> if_id_valid=0 for exactly one cycle while PC still advances by 4.
REQ-038 reset asserted together with redirect to 0x40 -> PC=RESET_PC and all outputs at their reset values.
